// File: rtl/keypad_event_scanner.sv
// Purpose: 4x4 matrix keypad scanner. It drives the columns, synchronizes and debounces the rows, and emits key events.
// Latency: a press is reported 2 + (DEBOUNCE_CNT-1..DEBOUNCE_CNT+4)*SCAN_DIV cycles after row settles; a release is reported about DEBOUNCE_CNT*SCAN_DIV cycles after.
// Backpressure: none; key_valid is a fire-and-forget strobe, so the consumer must take key_code in that cycle.
// Optional feature: define KEY_REPEAT_EN to re-strobe key_valid every REPEAT_CNT samples while a key is held.
module keypad_event_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8,
   parameter int REPEAT_CNT   = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] shift_col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [3:0] key_level,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int MW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [MW-1:0] DB_LAST  = MW'(DEBOUNCE_CNT - 1);

   localparam logic [1:0] S_SCAN     = 2'd0;
   localparam logic [1:0] S_DEBOUNCE = 2'd1;
   localparam logic [1:0] S_PRESSED  = 2'd2;

   logic [3:0]    row_m, row_s;
   logic [DW-1:0] div_cnt;
   logic          sample;
   logic [1:0]    state;
   logic [1:0]    col_idx;
   logic [1:0]    cand_row;
   logic [MW-1:0] match;
   logic [MW-1:0] rel;
   logic          cls_single, cls_none;
   logic [1:0]    row_idx;

`ifdef KEY_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CNT + 1);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CNT - 1);
   logic [RW-1:0] rpt;
`endif

   // The column index is the only scan state; the one-cold drive is decoded from it.
   assign shift_col = ~(4'b0001 << col_idx);
   assign sample    = (div_cnt == DIV_LAST);

   // Two-flop synchronizer for the asynchronous row returns. It idles at "no key".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_m <= 4'hF;
         row_s <= 4'hF;
      end else begin
         row_m <= row;
         row_s <= row_m;
      end
   end

   // Sample divider: one row sample every SCAN_DIV cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         div_cnt <= '0;
      else if (sample)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Classify the synchronized rows as a single key (with its index), no key, or several keys.
   always_comb begin
      cls_single = 1'b0;
      cls_none   = 1'b0;
      row_idx    = 2'd0;
      case (row_s)
         4'b1110: begin cls_single = 1'b1; row_idx = 2'd0; end
         4'b1101: begin cls_single = 1'b1; row_idx = 2'd1; end
         4'b1011: begin cls_single = 1'b1; row_idx = 2'd2; end
         4'b0111: begin cls_single = 1'b1; row_idx = 2'd3; end
         4'b1111: cls_none = 1'b1;
         default: ;
      endcase
   end

   // Scan / debounce / held state machine. It acts only on sample cycles and emits the key events.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_SCAN;
         col_idx   <= 2'd0;
         cand_row  <= 2'd0;
         match     <= '0;
         rel       <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_level <= 4'h0;
         key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
         rpt       <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (sample) begin
            case (state)
               S_SCAN: begin
                  if (cls_single) begin
                     // Park on this column and start counting matching samples.
                     cand_row <= row_idx;
                     match    <= MW'(1);
                     state    <= S_DEBOUNCE;
                  end else begin
                     col_idx <= col_idx + 2'd1;
                  end
               end
               S_DEBOUNCE: begin
                  if (cls_single && (row_idx == cand_row)) begin
                     if (match == DB_LAST) begin
                        key_valid <= 1'b1;
                        key_code  <= {cand_row, col_idx};
                        key_level <= {cand_row, col_idx};
                        key_held  <= 1'b1;
                        rel       <= '0;
                        state     <= S_PRESSED;
`ifdef KEY_REPEAT_EN
                        rpt       <= '0;
`endif
                     end else begin
                        match <= match + 1'b1;
                     end
                  end else begin
                     // The candidate did not hold. Drop it silently and move on.
                     match   <= '0;
                     state   <= S_SCAN;
                     col_idx <= col_idx + 2'd1;
                  end
               end
               S_PRESSED: begin
                  // Only a run of consecutive all-released samples ends the press.
                  // Any other key in this column just restarts that run.
                  if (cls_none) begin
                     if (rel == DB_LAST) begin
                        key_level <= 4'h0;
                        key_held  <= 1'b0;
                        rel       <= '0;
                        match     <= '0;
                        state     <= S_SCAN;
                        col_idx   <= col_idx + 2'd1;
                     end else begin
                        rel <= rel + 1'b1;
                     end
                  end else begin
                     rel <= '0;
                  end
`ifdef KEY_REPEAT_EN
                  if (cls_none)
                     rpt <= '0;
                  else if (rpt == RPT_LAST) begin
                     key_valid <= 1'b1;
                     rpt       <= '0;
                  end else
                     rpt <= rpt + 1'b1;
`endif
               end
               default: state <= S_SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Purpose: self-checking bench for keypad_event_scanner, driven through a behavioural 4x4 keypad.
// Latency: expected key codes are queued at stimulus time and compared when key_valid fires.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_keypad_event_scanner;

   localparam int SD = 4;
   localparam int DB = 3;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] row;
   logic [3:0] shift_col;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] key_level;
   logic       key_held;

   logic [15:0] pressed = '0;
   logic [3:0]  exp_q[$];
   logic [3:0]  e_code;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          nvalid = 0;

   keypad_event_scanner #(
      .SCAN_DIV    (SD),
      .DEBOUNCE_CNT(DB),
      .REPEAT_CNT  (RP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .row      (row),
      .shift_col(shift_col),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_level(key_level),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Keypad model: a pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !shift_col[c])
               row[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every key_valid strobe must match the next expected code.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset && key_valid) begin
            nvalid++;
            if (exp_q.size() == 0)
               check("unexpected_valid", 1, 0);
            else begin
               e_code = exp_q.pop_front();
               check("key_code", key_code, e_code);
               check("key_level_at_valid", key_level, e_code);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_empty(input string tag, input int bound, output int lat);
      lat = 0;
      while (exp_q.size() != 0 && lat < bound) begin
         tick(1);
         lat++;
      end
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_col(input string tag, input logic [3:0] col, input int bound);
      int n;
      n = 0;
      while (shift_col != col && n < bound) begin
         tick(1);
         n++;
      end
      check(tag, shift_col, col);
   endtask

   task automatic wait_release(input string tag, input int bound, output int lat);
      lat = 0;
      while (key_held && lat < bound) begin
         tick(1);
         lat++;
      end
      check(tag, key_held, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int n;
      int t0;
      int nv0;

      // Outputs must sit at their reset values while reset is held.
      reset = 1'b0;
      tick(3);
      check("rst_shift_col", shift_col, 4'b1110);
      check("rst_key_code", key_code, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_level", key_level, 0);
      check("rst_key_held", key_held, 0);
      reset = 1'b1;

      // Once released, the scan rotates one column every SD cycles.
      wait_col("rot_c1", 4'b1101, 8);
      n = 0;
      while (shift_col == 4'b1101 && n < 10) begin
         tick(1);
         n++;
      end
      check("rot_period", n, SD);
      check("rot_c2", shift_col, 4'b1011);

      // Clean press of the "ok" key (r3,c3), then release.
      pressed[15] = 1'b1;
      exp_q.push_back(4'hF);
      wait_empty("press_F", 40, lat);
      check("press_lat_max", lat <= 2 + 4*SD + DB*SD, 1);
      check("press_lat_min", lat >= 2 + (DB-1)*SD, 1);
      check("level_F", key_level, 4'hF);
      check("held_F", key_held, 1);
      pressed[15] = 1'b0;
      wait_release("rel_F", 30, lat);
      check("rel_lat", lat <= 18, 1);
      check("level_F_clear", key_level, 0);

      // Bounce: r1 on c1 lasts only two samples, so no event occurs and the scan resumes at c2.
      wait_col("bc_c0", 4'b1110, 20);
      wait_col("bc_c1", 4'b1101, 8);
      pressed[5] = 1'b1;
      tick(7);
      pressed[5] = 1'b0;
      wait_col("bc_c2", 4'b1011, 8);
      tick(4);
      check("bc_no_held", key_held, 0);

      // Multi-key on c1 (r0 and r2 together): no event, and the column advances.
      wait_col("mk_c0", 4'b1110, 20);
      pressed[1] = 1'b1;
      pressed[9] = 1'b1;
      wait_col("mk_c1", 4'b1101, 8);
      wait_col("mk_c2", 4'b1011, 8);
      check("mk_no_held", key_held, 0);
      pressed[1] = 1'b0;
      pressed[9] = 1'b0;

      // r0 is pressed first and accepted. A later r2 in the same column is ignored.
      pressed[1] = 1'b1;
      exp_q.push_back(4'h1);
      wait_empty("press_1", 40, lat);
      pressed[9] = 1'b1;
      tick(8);
      check("r2_ignored_code", key_code, 4'h1);
      check("r2_ignored_level", key_level, 4'h1);
      check("r2_parked_col", shift_col, 4'b1101);
      check("r2_still_held", key_held, 1);
      pressed[1] = 1'b0;
      pressed[9] = 1'b0;
      wait_release("rel_1", 30, lat);

      // A reset during a held press clears everything, and the still-held key is detected again.
      pressed[6] = 1'b1;
      exp_q.push_back(4'h6);
      wait_empty("press_6", 40, lat);
      reset = 1'b0;
      tick(2);
      check("midrst_level", key_level, 0);
      check("midrst_held", key_held, 0);
      check("midrst_code", key_code, 0);
      check("midrst_col", shift_col, 4'b1110);
      exp_q.push_back(4'h6);
      reset = 1'b1;
      wait_empty("repress_6", 40, lat);
      check("repress_held", key_held, 1);
      pressed[6] = 1'b0;
      wait_release("rel_6", 30, lat);

      // Hold key 9: it re-strobes every RP samples with repeat enabled, and strobes once otherwise.
      pressed[9] = 1'b1;
      exp_q.push_back(4'h9);
      wait_empty("press_9", 40, lat);
      t0 = cyc;
      nv0 = nvalid;
`ifdef KEY_REPEAT_EN
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(4'h9);
         wait_empty("rpt_9", 30, lat);
         check("rpt_gap", cyc - t0, RP*SD);
         t0 = cyc;
      end
`else
      tick(60);
      check("one_strobe", nvalid - nv0, 0);
      check("held_9", key_held, 1);
`endif
      pressed[9] = 1'b0;
      wait_release("rel_9", 30, lat);
      check("level_9_clear", key_level, 0);

      tick(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
